async_receiver: RTL and testbench
=================================

Name: async_receiver

Overview:
- RS-232 (UART) receiver, 8N1, LSB first. It takes the serial line from the host PC and delivers bytes to the event builder's command/configuration path.
- It is the receive-side counterpart of the diagnostic UART transmitter: same baud parameters, same frame format.
- It oversamples the line, validates the start bit, majority-votes each bit and flags framing errors.

Parameters:
- ClkFrequency, 100000000, system clock frequency in Hz
- Baud, 115200, line rate in bits/s
- Oversampling, 16, samples per bit period; must be even and ≥ 8
- Divisor, (ClkFrequency + Baud*Oversampling/2)/(Baud*Oversampling), clocks per oversample tick (rounded); 54 at defaults

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- RxD  in  1  asynchronous serial input, idle high
- RxD_data  out  8  last received byte, held until the next byte completes
- RxD_data_ready  out  1  one-cycle pulse: RxD_data valid and stop bit good
- RxD_error  out  1  one-cycle pulse: framing error (stop bit sampled 0)
- RxD_busy  out  1  high from start-bit detection until the frame ends
- RxD_idle  out  1  high once the line has stayed high ≥ 10 bit periods with the receiver in IDLE

Behaviour:
- Reset values:
  - RxD_data=0, RxD_data_ready=0, RxD_error=0, RxD_busy=0, RxD_idle=0.
  - Synchronizer flops=1, state=IDLE, all counters=0.
  - Reset dominates every other event in the same cycle.
- Synchronizer: RxD passes through 2 flops → rxs. The sampling logic uses only rxs.
- Tick generator:
  - Counter runs 0..Divisor-1; tick asserts for one cycle when count==Divisor-1.
  - Counter is cleared in IDLE and on the start-bit detect cycle, so bit timing is phase-aligned to the falling edge.
- Bit timing:
  - tick_cnt (width log2(Oversampling)) counts ticks within a bit, wrapping Oversampling-1→0.
  - rxs is captured on the ticks where tick_cnt = M-1, M, M+1, with M = Oversampling/2.
  - bit value = majority of the 3 captures, evaluated on the M+1 tick.
- State machine:
  - IDLE: when rxs==0, go to START, clear tick_cnt and divider, set busy.
  - START: at the majority point, 0 → DATA with bit index 0. A vote of 1 is a false start: → IDLE, busy cleared.
  - DATA: at each bit's majority point, shift the vote into the MSB of the shift register (LSB-first arrival). After bit index 7 → STOP.
  - STOP, at the majority point:
    - vote 1: load RxD_data from the shift register, pulse RxD_data_ready next cycle, → IDLE immediately (mid stop bit), so back-to-back frames with 1 stop bit are received.
    - vote 0: RxD_data unchanged, pulse RxD_error, → BREAK.
  - BREAK: stay until rxs==1, then → IDLE. busy stays high in BREAK.
- Latency: RxD_data_ready rises 1 clk after the stop-bit majority tick, ≈ 9.5 bit periods + 2-3 clk after the RxD falling edge.
- Idle counter:
  - Counts ticks while state==IDLE and rxs==1; any low sample clears it.
  - RxD_idle=1 when count ≥ 10*Oversampling; the counter saturates there.
  - RxD_idle drops the cycle rxs goes low.
- Data_ready and error never assert in the same cycle.

Test Plan (sim params ClkFrequency=3200000, Baud=100000, Oversampling=16 → Divisor=2, 32 clk/bit; reset then RxD=1 for 400 clk):
1. Reset/idle: all outputs 0 after reset; RxD_idle rises after 320-324 clk of high line; RxD_busy=0 throughout.
2. Send 0x55, 1 stop bit: exactly one RxD_data_ready pulse 304±4 clk after the falling edge; RxD_data=0x55; RxD_error never asserts; busy falls with the ready pulse.
3. Glitch: RxD low for 8 clk, then high → no ready/error pulse; busy high for ≤ 24 clk and then low; state returns to IDLE.
4. Framing: send 0xA3 with the stop bit driven 0 for 64 clk → one RxD_error pulse, no ready, RxD_data keeps its prior value, busy stays high until the line returns high.
5. Back-to-back 0x00 then 0xFF with 1 stop bit, no gap → two ready pulses 320 clk apart; RxD_data=0x00 then 0xFF.
6. Baud skew and mid-frame reset:
   - Transmit 0x3C with bit period 31 clk, then 33 clk → received 0x3C both times.
   - Assert reset during bit 4 → no pulse; the next 0x3C frame is received cleanly.

Source files
------------

// File: rtl/async_receiver.sv
// 8N1 UART receiver: two-flop synchronizer, oversampled bit timing with a
// three-sample majority vote, framing-error and line-idle detection.
module async_receiver #(
  parameter int ClkFrequency = 100000000,
  parameter int Baud         = 115200,
  parameter int Oversampling = 16,
  parameter int Divisor      = (ClkFrequency + Baud*Oversampling/2) / (Baud*Oversampling)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       RxD_error,
  output logic       RxD_busy,
  output logic       RxD_idle
);

  localparam int DivW      = (Divisor > 1) ? $clog2(Divisor) : 1;
  localparam int TickW     = $clog2(Oversampling);
  localparam int Mid       = Oversampling / 2;
  localparam int IdleLimit = 10 * Oversampling * Divisor;
  localparam int IdleW     = $clog2(IdleLimit + 1);

  typedef enum logic [2:0] {sIdle, sStart, sData, sStop, sBreak} stateType;

  stateType           state;
  logic               sync1;
  logic               rxs;
  logic [DivW-1:0]    divCnt;
  logic [TickW-1:0]   tickCnt;
  logic [TickW-1:0]   tickNext;
  logic [2:0]         bitIdx;
  logic [1:0]         samples;
  logic [7:0]         shiftReg;
  logic [IdleW-1:0]   idleCnt;
  logic               tick;
  logic               inWindow;
  logic               votePoint;
  logic               vote;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Two-flop synchronizer; reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= RxD;
      rxs   <= sync1;
    end
  end

  // Oversample divider, held at zero in IDLE so timing aligns to the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt <= {DivW{1'b0}};
    end else if (state == sIdle || tick) begin
      divCnt <= {DivW{1'b0}};
    end else begin
      divCnt <= divCnt + DivW'(1);
    end
  end

  assign tick = (divCnt == DivW'(Divisor - 1));

  // tickNext is the count after this tick; the capture window is keyed on it.
  always_comb begin
    tickNext = tickCnt + TickW'(1);
    if (tickCnt == TickW'(Oversampling - 1)) begin
      tickNext = {TickW{1'b0}};
    end else begin
      tickNext = tickCnt + TickW'(1);
    end
  end

  assign inWindow  = tick && (tickNext >= TickW'(Mid - 1)) && (tickNext <= TickW'(Mid + 1));
  assign votePoint = tick && (tickNext == TickW'(Mid + 1));
  assign vote      = maj3(samples[1], samples[0], rxs);

  // Idle detector counts clocks (one tick is Divisor clocks) since the divider is parked in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      idleCnt  <= {IdleW{1'b0}};
      RxD_idle <= 1'b0;
    end else if (state == sIdle && rxs) begin
      if (idleCnt != IdleW'(IdleLimit)) begin
        idleCnt <= idleCnt + IdleW'(1);
      end
      RxD_idle <= (idleCnt >= IdleW'(IdleLimit - 1));
    end else begin
      idleCnt  <= {IdleW{1'b0}};
      RxD_idle <= 1'b0;
    end
  end

  // Frame state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= sIdle;
      tickCnt        <= {TickW{1'b0}};
      bitIdx         <= 3'd0;
      samples        <= 2'b00;
      shiftReg       <= 8'h00;
      RxD_data       <= 8'h00;
      RxD_data_ready <= 1'b0;
      RxD_error      <= 1'b0;
      RxD_busy       <= 1'b0;
    end else begin
      RxD_data_ready <= 1'b0;
      RxD_error      <= 1'b0;
      if (tick) begin
        tickCnt <= tickNext;
      end
      if (inWindow) begin
        samples <= {samples[0], rxs};
      end
      case (state)
        sIdle: begin
          if (!rxs) begin
            state    <= sStart;
            tickCnt  <= {TickW{1'b0}};
            bitIdx   <= 3'd0;
            RxD_busy <= 1'b1;
          end
        end
        sStart: begin
          if (votePoint) begin
            if (!vote) begin
              state  <= sData;
              bitIdx <= 3'd0;
            end else begin
              state    <= sIdle;
              RxD_busy <= 1'b0;
            end
          end
        end
        sData: begin
          if (votePoint) begin
            shiftReg <= {vote, shiftReg[7:1]};
            if (bitIdx == 3'd7) begin
              state <= sStop;
            end else begin
              bitIdx <= bitIdx + 3'd1;
            end
          end
        end
        // Return to IDLE mid stop bit so a following start edge is not missed.
        sStop: begin
          if (votePoint) begin
            if (vote) begin
              RxD_data       <= shiftReg;
              RxD_data_ready <= 1'b1;
              RxD_busy       <= 1'b0;
              state          <= sIdle;
            end else begin
              RxD_error <= 1'b1;
              state     <= sBreak;
            end
          end
        end
        sBreak: begin
          if (rxs) begin
            state    <= sIdle;
            RxD_busy <= 1'b0;
          end
        end
        default: begin
          state    <= sIdle;
          RxD_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_async_receiver.sv
// Self-checking bench for async_receiver: a timing-level reference model checked
// every cycle, plus directed and randomized frames with literal expectations.
module tb_async_receiver;

  localparam int ClkFreq  = 3200000;
  localparam int BaudRate = 100000;
  localparam int Os       = 16;
  localparam int Div      = (ClkFreq + BaudRate*Os/2) / (BaudRate*Os);
  localparam int Mid      = Os / 2;
  localparam int IdleT    = 10 * Os * Div;

  logic       clk;
  logic       reset;
  logic       RxD;
  logic [7:0] RxD_data;
  logic       RxD_data_ready;
  logic       RxD_error;
  logic       RxD_busy;
  logic       RxD_idle;

  async_receiver #(
    .ClkFrequency(ClkFreq),
    .Baud(BaudRate),
    .Oversampling(Os)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RxD(RxD),
    .RxD_data(RxD_data),
    .RxD_data_ready(RxD_data_ready),
    .RxD_error(RxD_error),
    .RxD_busy(RxD_busy),
    .RxD_idle(RxD_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observation statistics, attributed to the rising edge that produced them.
  int edgeN = 0;
  bit started = 1'b0;
  int readyCnt = 0;
  int errorCnt = 0;
  int lastReadyEdge = -1;
  int prevReadyEdge = -1;
  int idleRiseEdge = -1;
  int busyRun = 0;
  int busyRunMax = 0;
  int busyAtReady = 0;
  logic [7:0] rxQ[$];

  // Reference model: line history plus frame timing from the detect edge.
  int mMode = 0;            // 0 idle, 1 in frame, 2 break
  int mDet = 0;
  int mIdleCnt = 0;
  bit mSmp[3];
  logic [7:0] mAcc = 8'h00;
  logic [7:0] eData = 8'h00;
  bit eReady = 1'b0, eError = 1'b0, eBusy = 1'b0, eIdle = 1'b0;
  bit eff1 = 1'b1, eff2 = 1'b1;

  task automatic modelStep(input bit r, input bit d);
    bit seen;
    int rel, k, b, t, votes;
    if (r) begin
      eff1 = 1'b1; eff2 = 1'b1;
      mMode = 0; mIdleCnt = 0; mAcc = 8'h00;
      eData = 8'h00; eReady = 1'b0; eError = 1'b0; eBusy = 1'b0; eIdle = 1'b0;
      started = 1'b1;
      return;
    end
    seen = eff2;           // the receiver sees the line two clocks late
    eff2 = eff1;
    eff1 = d;
    eReady = 1'b0;
    eError = 1'b0;
    if (mMode == 0) begin
      if (seen) begin
        if (mIdleCnt < IdleT) mIdleCnt++;
        eIdle = (mIdleCnt >= IdleT);
      end else begin
        mIdleCnt = 0; eIdle = 1'b0;
        mMode = 1; mDet = edgeN; eBusy = 1'b1; mAcc = 8'h00;
      end
    end else if (mMode == 1) begin
      mIdleCnt = 0; eIdle = 1'b0;
      rel = edgeN - mDet;
      if (rel % Div == 0) begin
        k = rel / Div;
        b = (k - 1) / Os;
        t = k - Os*b;
        if (t >= Mid-1 && t <= Mid+1) mSmp[t-(Mid-1)] = seen;
        if (t == Mid+1) begin
          votes = int'(mSmp[0]) + int'(mSmp[1]) + int'(mSmp[2]);
          if (b == 0) begin
            if (votes >= 2) begin mMode = 0; eBusy = 1'b0; end
          end else if (b <= 8) begin
            mAcc[b-1] = (votes >= 2);
          end else begin
            if (votes >= 2) begin
              eData = mAcc; eReady = 1'b1; mMode = 0; eBusy = 1'b0;
            end else begin
              eError = 1'b1; mMode = 2;
            end
          end
        end
      end
    end else begin
      mIdleCnt = 0; eIdle = 1'b0;
      if (seen) begin mMode = 0; eBusy = 1'b0; end
    end
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      edgeN++;
      modelStep(reset, RxD);
      @(negedge clk);
      if (started) begin
        checks++;
        if ({RxD_data, RxD_data_ready, RxD_error, RxD_busy, RxD_idle} !==
            {eData, eReady, eError, eBusy, eIdle}) begin
          errors++;
          $display("FAIL cycle_model @edge %0d: dut data=%h rdy=%b err=%b busy=%b idle=%b, expected data=%h rdy=%b err=%b busy=%b idle=%b",
                   edgeN, RxD_data, RxD_data_ready, RxD_error, RxD_busy, RxD_idle,
                   eData, eReady, eError, eBusy, eIdle);
        end
      end
      if (RxD_data_ready === 1'b1) begin
        readyCnt++;
        prevReadyEdge = lastReadyEdge;
        lastReadyEdge = edgeN;
        busyAtReady = int'(RxD_busy);
        rxQ.push_back(RxD_data);
      end
      if (RxD_error === 1'b1) errorCnt++;
      if (RxD_idle === 1'b1 && idleRiseEdge < 0) idleRiseEdge = edgeN;
      if (RxD_busy === 1'b1) begin
        busyRun++;
        if (busyRun > busyRunMax) busyRunMax = busyRun;
      end else begin
        busyRun = 0;
      end
    end
  end

  task automatic checkRange(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Inputs change 1 time unit after the falling edge, well away from the sampling edge.
  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int fallEdge = 0;

  task automatic sendData(input logic [7:0] b, input int bitLen);
    RxD = 1'b0;
    fallEdge = edgeN + 1;
    waitClk(bitLen);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      waitClk(bitLen);
    end
  endtask

  int rc0, ec0;
  logic [7:0] rb;
  int bl, kind, gl;

  initial begin : stimulus
    reset = 1'b1;
    RxD   = 1'b1;
    waitClk(5);
    checkRange("reset_data", int'(RxD_data), 0, 0);
    checkRange("reset_flags", int'({RxD_data_ready, RxD_error, RxD_busy, RxD_idle}), 0, 0);
    reset = 1'b0;

    // Idle detection on a steady high line
    rc0 = edgeN; idleRiseEdge = -1; busyRunMax = 0;
    waitClk(400);
    checkRange("idle_rise_delay", idleRiseEdge - rc0, 320, 324);
    checkRange("idle_busy_never", busyRunMax, 0, 0);

    // Single 0x55 frame
    rc0 = readyCnt; ec0 = errorCnt; rxQ.delete();
    sendData(8'h55, 32);
    RxD = 1'b1;
    waitClk(64);
    checkRange("x55_ready_count", readyCnt - rc0, 1, 1);
    checkRange("x55_error_count", errorCnt - ec0, 0, 0);
    checkRange("x55_latency", lastReadyEdge - fallEdge, 300, 308);
    checkRange("x55_data", int'(RxD_data), 8'h55, 8'h55);
    checkRange("x55_busy_at_ready", busyAtReady, 0, 0);

    // 8-clock glitch is a false start
    rc0 = readyCnt; ec0 = errorCnt; busyRunMax = 0;
    RxD = 1'b0;
    waitClk(8);
    RxD = 1'b1;
    waitClk(100);
    checkRange("glitch_no_ready", readyCnt - rc0, 0, 0);
    checkRange("glitch_no_error", errorCnt - ec0, 0, 0);
    checkRange("glitch_busy_len", busyRunMax, 1, 24);
    checkRange("glitch_busy_low", int'(RxD_busy), 0, 0);

    // Framing error: 0xA3 with stop bit held low
    rc0 = readyCnt; ec0 = errorCnt;
    sendData(8'hA3, 32);
    RxD = 1'b0;
    waitClk(64);
    checkRange("frame_error_count", errorCnt - ec0, 1, 1);
    checkRange("frame_no_ready", readyCnt - rc0, 0, 0);
    checkRange("frame_data_kept", int'(RxD_data), 8'h55, 8'h55);
    checkRange("frame_busy_in_break", int'(RxD_busy), 1, 1);
    RxD = 1'b1;
    waitClk(10);
    checkRange("frame_busy_released", int'(RxD_busy), 0, 0);
    waitClk(100);

    // Back-to-back 0x00 then 0xFF
    rxQ.delete();
    sendData(8'h00, 32);
    RxD = 1'b1;
    waitClk(32);
    sendData(8'hFF, 32);
    RxD = 1'b1;
    waitClk(100);
    checkRange("b2b_count", rxQ.size(), 2, 2);
    if (rxQ.size() == 2) begin
      checkRange("b2b_first", int'(rxQ[0]), 8'h00, 8'h00);
      checkRange("b2b_second", int'(rxQ[1]), 8'hFF, 8'hFF);
      checkRange("b2b_spacing", lastReadyEdge - prevReadyEdge, 320, 320);
    end

    // Baud skew: 31 and 33 clocks per bit
    for (int s = 0; s < 2; s++) begin
      rxQ.delete();
      bl = (s == 0) ? 31 : 33;
      sendData(8'h3C, bl);
      RxD = 1'b1;
      waitClk(bl + 60);
      checkRange("skew_count", rxQ.size(), 1, 1);
      if (rxQ.size() == 1) checkRange("skew_data", int'(rxQ[0]), 8'h3C, 8'h3C);
    end

    // Reset in the middle of bit 4, then a clean frame
    rc0 = readyCnt; ec0 = errorCnt; rb = 8'h3C;
    RxD = 1'b0;
    waitClk(32);
    for (int i = 0; i < 4; i++) begin
      RxD = rb[i];
      waitClk(32);
    end
    RxD = rb[4];
    waitClk(12);
    reset = 1'b1;
    waitClk(2);
    reset = 1'b0;
    RxD = 1'b1;
    waitClk(400);
    checkRange("midreset_no_ready", readyCnt - rc0, 0, 0);
    checkRange("midreset_no_error", errorCnt - ec0, 0, 0);
    checkRange("midreset_data_cleared", int'(RxD_data), 0, 0);
    rxQ.delete();
    sendData(8'h3C, 32);
    RxD = 1'b1;
    waitClk(64);
    checkRange("after_reset_count", rxQ.size(), 1, 1);
    if (rxQ.size() == 1) checkRange("after_reset_data", int'(rxQ[0]), 8'h3C, 8'h3C);

    // Randomized frames, glitches and framing errors against the model
    for (int n = 0; n < 24; n++) begin
      rb = 8'($urandom);
      bl = $urandom_range(31, 33);
      kind = $urandom_range(0, 9);
      rxQ.delete();
      rc0 = errorCnt;
      if (kind == 0) begin
        gl = $urandom_range(2, 12);
        RxD = 1'b0;
        waitClk(gl);
        RxD = 1'b1;
        waitClk(40);
        checkRange("rand_glitch_quiet", rxQ.size() + errorCnt - rc0, 0, 0);
      end else if (kind == 1) begin
        sendData(rb, bl);
        RxD = 1'b0;
        waitClk($urandom_range(40, 80));
        RxD = 1'b1;
        waitClk(5);
        checkRange("rand_frame_error", errorCnt - rc0, 1, 1);
        checkRange("rand_frame_no_data", rxQ.size(), 0, 0);
      end else begin
        sendData(rb, bl);
        RxD = 1'b1;
        waitClk(bl);
        checkRange("rand_count", rxQ.size(), 1, 1);
        if (rxQ.size() == 1) checkRange("rand_data", int'(rxQ[0]), int'(rb), int'(rb));
        waitClk($urandom_range(0, 40));
      end
    end
    waitClk(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
